// File: rtl/ram_arbiter.sv
// Round-robin arbiter and power-up initialiser for a single-port 16x8 synchronous-read RAM.
// Clears the RAM after reset, then shares its one port between requesters A and B.
module ram_arbiter #(
    parameter int              AW       = 4,
    parameter int              DW       = 8,
    parameter logic [DW-1:0]   INIT_VAL = 8'h00
) (
    input  logic          clk,
    input  logic          rst,
    output logic          init_done,
    output logic [0:0]    dbg_state,

    input  logic          a_valid,
    output logic          a_ready,
    input  logic          a_we,
    input  logic [AW-1:0] a_adr,
    input  logic [DW-1:0] a_dat_w,
    output logic          a_rsp_valid,
    output logic [DW-1:0] a_dat_r,

    input  logic          b_valid,
    output logic          b_ready,
    input  logic          b_we,
    input  logic [AW-1:0] b_adr,
    input  logic [DW-1:0] b_dat_w,
    output logic          b_rsp_valid,
    output logic [DW-1:0] b_dat_r,

    output logic [AW-1:0] mem_adr,
    output logic          mem_we,
    output logic [DW-1:0] mem_dat_w,
    input  logic [DW-1:0] mem_dat_r
);

    localparam logic [0:0] ST_INIT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [0:0]    state;
    logic [AW-1:0] cnt;
    logic          last_b;
    logic          iss_vld;
    logic          iss_id;
    logic          iss_we;
    logic          run;
    logic          gnt_a;
    logic          gnt_b;

    // Handshake: a request transfers in the cycle where x_valid and x_ready are both high;
    // the requester holds adr/we/dat_w stable until then, and its response follows one cycle later.
    // Outputs are gated with rst so they fall to zero the moment reset is asserted.
    assign run       = ~rst & (state == ST_RUN);
    assign init_done = run;
    assign dbg_state = state;

    always_comb begin
        gnt_a = 1'b0;
        gnt_b = 1'b0;
        if (run) begin
            gnt_a = a_valid & (~b_valid | last_b);
            gnt_b = b_valid & (~a_valid | ~last_b);
        end
    end

    assign a_ready = gnt_a;
    assign b_ready = gnt_b;

    always_comb begin
        mem_we    = 1'b0;
        mem_adr   = '0;
        mem_dat_w = '0;
        if (!rst && state == ST_INIT) begin
            mem_we    = 1'b1;
            mem_adr   = cnt;
            mem_dat_w = INIT_VAL;
        end else if (gnt_a) begin
            mem_we    = a_we;
            mem_adr   = a_adr;
            mem_dat_w = a_dat_w;
        end else if (gnt_b) begin
            mem_we    = b_we;
            mem_adr   = b_adr;
            mem_dat_w = b_dat_w;
        end
    end

    // Read data arrives from the RAM in the cycle after the grant, matching the issue register.
    assign a_rsp_valid = ~rst & iss_vld & ~iss_id;
    assign b_rsp_valid = ~rst & iss_vld & iss_id;
    assign a_dat_r     = (a_rsp_valid && !iss_we) ? mem_dat_r : '0;
    assign b_dat_r     = (b_rsp_valid && !iss_we) ? mem_dat_r : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_INIT;
            cnt     <= '0;
            last_b  <= 1'b1;
            iss_vld <= 1'b0;
            iss_id  <= 1'b0;
            iss_we  <= 1'b0;
        end else begin
            if (state == ST_INIT) begin
                cnt <= cnt + 1'b1;
                if (cnt == {AW{1'b1}})
                    state <= ST_RUN;
            end
            iss_vld <= gnt_a | gnt_b;
            iss_id  <= gnt_b;
            iss_we  <= gnt_b ? b_we : (gnt_a & a_we);
            if (gnt_a || gnt_b)
                last_b <= gnt_b;
        end
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: RAM model, per-cycle behavioural reference, directed scenarios
// with hand-computed expectations.
module tb_ram_arbiter;

    localparam int AW = 4;
    localparam int DW = 8;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          init_done;
    logic [0:0]    dbg_state;
    logic          a_valid, a_ready, a_we, a_rsp_valid;
    logic [AW-1:0] a_adr;
    logic [DW-1:0] a_dat_w, a_dat_r;
    logic          b_valid, b_ready, b_we, b_rsp_valid;
    logic [AW-1:0] b_adr;
    logic [DW-1:0] b_dat_w, b_dat_r;
    logic [AW-1:0] mem_adr;
    logic          mem_we;
    logic [DW-1:0] mem_dat_w, mem_dat_r;

    int n_checks = 0;
    int n_err    = 0;

    ram_arbiter #(.AW(AW), .DW(DW), .INIT_VAL(8'h00)) dut (
        .clk(clk), .rst(rst), .init_done(init_done), .dbg_state(dbg_state),
        .a_valid(a_valid), .a_ready(a_ready), .a_we(a_we), .a_adr(a_adr),
        .a_dat_w(a_dat_w), .a_rsp_valid(a_rsp_valid), .a_dat_r(a_dat_r),
        .b_valid(b_valid), .b_ready(b_ready), .b_we(b_we), .b_adr(b_adr),
        .b_dat_w(b_dat_w), .b_rsp_valid(b_rsp_valid), .b_dat_r(b_dat_r),
        .mem_adr(mem_adr), .mem_we(mem_we), .mem_dat_w(mem_dat_w), .mem_dat_r(mem_dat_r)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- RAM: address registered on the edge, data read combinationally ----------------
    logic [DW-1:0] ram [DEPTH];
    logic [AW-1:0] ram_adr_q;
    initial begin
        for (int i = 0; i < DEPTH; i++) ram[i] = 8'hAA;
        ram_adr_q = '0;
    end
    always @(posedge clk) begin
        if (mem_we) ram[mem_adr] <= mem_dat_w;
        ram_adr_q <= mem_adr;
    end
    assign mem_dat_r = ram[ram_adr_q];

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    // ---------------- behavioural reference ----------------
    int            m_init_left;
    bit            m_prefer_a;
    logic [DW-1:0] shadow [DEPTH];
    bit            p_vld, p_id;
    logic [DW-1:0] p_dat;
    bit            ga, gb;
    logic          s_a_we, s_b_we;
    logic [AW-1:0] s_a_adr, s_b_adr;
    logic [DW-1:0] s_a_dw, s_b_dw;

    initial for (int i = 0; i < DEPTH; i++) shadow[i] = 8'hAA;

    always begin
        @(negedge clk);
        ga = 1'b0;
        gb = 1'b0;
        if (rst) begin
            m_init_left = DEPTH;
            m_prefer_a  = 1'b1;
            p_vld       = 1'b0;
            chk("rst_init_done", init_done, 0);
            chk("rst_mem_we", mem_we, 0);
            chk("rst_mem_adr", mem_adr, 0);
            chk("rst_mem_dat_w", mem_dat_w, 0);
            chk("rst_ready", {a_ready, b_ready}, 0);
            chk("rst_rsp", {a_rsp_valid, b_rsp_valid}, 0);
            chk("rst_dat_r", {a_dat_r, b_dat_r}, 0);
        end else begin
            s_a_we = a_we; s_a_adr = a_adr; s_a_dw = a_dat_w;
            s_b_we = b_we; s_b_adr = b_adr; s_b_dw = b_dat_w;
            if (m_init_left > 0) begin
                chk("m_init_done", init_done, 0);
                chk("m_mem_we", mem_we, 1);
                chk("m_mem_adr", mem_adr, DEPTH - m_init_left);
                chk("m_mem_dat_w", mem_dat_w, 8'h00);
                chk("m_ready", {a_ready, b_ready}, 0);
            end else begin
                ga = a_valid && (!b_valid || m_prefer_a);
                gb = b_valid && !ga;
                chk("m_init_done", init_done, 1);
                chk("m_a_ready", a_ready, ga);
                chk("m_b_ready", b_ready, gb);
                chk("m_mem_we", mem_we, ga ? s_a_we : (gb ? s_b_we : 1'b0));
                chk("m_mem_adr", mem_adr, ga ? s_a_adr : (gb ? s_b_adr : 4'h0));
                chk("m_mem_dat_w", mem_dat_w, ga ? s_a_dw : (gb ? s_b_dw : 8'h00));
            end
            chk("m_a_rsp_valid", a_rsp_valid, p_vld && !p_id);
            chk("m_b_rsp_valid", b_rsp_valid, p_vld && p_id);
            chk("m_a_dat_r", a_dat_r, (p_vld && !p_id) ? p_dat : 8'h00);
            chk("m_b_dat_r", b_dat_r, (p_vld && p_id) ? p_dat : 8'h00);
        end
        @(posedge clk);
        if (!rst) begin
            p_vld = 1'b0;
            if (m_init_left > 0) begin
                shadow[DEPTH - m_init_left] = 8'h00;
                m_init_left--;
            end else if (ga || gb) begin
                p_vld      = 1'b1;
                p_id       = gb;
                m_prefer_a = gb;
                if (ga) begin
                    p_dat = s_a_we ? 8'h00 : shadow[s_a_adr];
                    if (s_a_we) shadow[s_a_adr] = s_a_dw;
                end else begin
                    p_dat = s_b_we ? 8'h00 : shadow[s_b_adr];
                    if (s_b_we) shadow[s_b_adr] = s_b_dw;
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic drive_a(input logic v, input logic we, input logic [AW-1:0] adr, input logic [DW-1:0] d);
        a_valid = v; a_we = we; a_adr = adr; a_dat_w = d;
    endtask

    task automatic drive_b(input logic v, input logic we, input logic [AW-1:0] adr, input logic [DW-1:0] d);
        b_valid = v; b_we = we; b_adr = adr; b_dat_w = d;
    endtask

    // ---------------- directed scenarios ----------------
    initial begin
        rst = 1'b1;
        drive_a(0, 0, 0, 0);
        drive_b(0, 0, 0, 0);
        repeat (2) tick();

        // Release reset with A already requesting a read of 7.
        rst = 1'b0;
        drive_a(1, 0, 4'h7, 8'h00);
        for (int i = 0; i < DEPTH; i++) begin
            sample();
            chk("init_we", mem_we, 1);
            chk("init_adr", mem_adr, i);
            chk("init_a_ready", a_ready, 0);
        end
        sample();
        chk("c16_init_done", init_done, 1);
        chk("c16_a_ready", a_ready, 1);
        tick();
        drive_a(0, 0, 0, 0);
        sample();
        chk("rd7_rsp", a_rsp_valid, 1);
        chk("rd7_dat", a_dat_r, 8'h00);

        // Write 3=5A then read 3 back to back.
        tick(); drive_a(1, 1, 4'h3, 8'h5A);
        sample(); chk("wr3_ready", a_ready, 1);
        tick(); drive_a(1, 0, 4'h3, 8'h00);
        sample(); chk("wr3_rsp", a_rsp_valid, 1); chk("wr3_dat", a_dat_r, 8'h00);
        tick(); drive_a(0, 0, 0, 0);
        sample(); chk("rd3_rsp", a_rsp_valid, 1); chk("rd3_dat", a_dat_r, 8'h5A);

        // Seed 2=22 (A) and 1=11 (B); B last granted, so A wins the first tie.
        tick(); drive_a(1, 1, 4'h2, 8'h22);
        sample(); chk("wr2_ready", a_ready, 1);
        tick(); drive_a(0, 0, 0, 0); drive_b(1, 1, 4'h1, 8'h11);
        sample(); chk("wr1_ready", b_ready, 1);
        tick(); drive_a(1, 0, 4'h1, 8'h00); drive_b(1, 0, 4'h2, 8'h00);
        for (int k = 0; k < 4; k++) begin
            sample();
            chk("rr_a_ready", a_ready, (k % 2) == 0);
            chk("rr_b_ready", b_ready, (k % 2) == 1);
            if (k > 0) begin
                if (((k - 1) % 2) == 0) begin
                    chk("rr_a_rsp", a_rsp_valid, 1); chk("rr_a_dat", a_dat_r, 8'h11);
                end else begin
                    chk("rr_b_rsp", b_rsp_valid, 1); chk("rr_b_dat", b_dat_r, 8'h22);
                end
            end
            if (k < 3) tick();
        end
        tick(); drive_a(0, 0, 0, 0); drive_b(0, 0, 0, 0);
        sample(); chk("rr_b_rsp_last", b_rsp_valid, 1); chk("rr_b_dat_last", b_dat_r, 8'h22);

        // A read of 0 makes A most recent, then same-address collision on F.
        tick(); drive_a(1, 0, 4'h0, 8'h00);
        sample(); chk("rd0_ready", a_ready, 1);
        tick(); drive_a(1, 0, 4'hF, 8'h00); drive_b(1, 1, 4'hF, 8'hC3);
        sample(); chk("col_b_ready", b_ready, 1); chk("col_a_ready", a_ready, 0);
        tick(); drive_b(0, 0, 0, 0);
        sample(); chk("col_a_ready2", a_ready, 1); chk("col_b_rsp", b_rsp_valid, 1);
        chk("col_b_dat", b_dat_r, 8'h00);
        tick(); drive_a(0, 0, 0, 0);
        sample(); chk("col_a_rsp", a_rsp_valid, 1); chk("col_a_dat", a_dat_r, 8'hC3);

        // Reset with a read of 3 in flight.
        tick(); drive_a(1, 0, 4'h3, 8'h00);
        sample(); chk("pre_rst_ready", a_ready, 1);
        tick();
        rst = 1'b1;
        drive_a(0, 0, 0, 0);
        #1;
        chk("async_rsp", a_rsp_valid, 0);
        chk("async_dat", a_dat_r, 0);
        chk("async_mem_we", mem_we, 0);
        chk("async_mem_adr", mem_adr, 0);
        chk("async_init_done", init_done, 0);
        tick();
        rst = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            sample();
            chk("reinit_no_rsp", {a_rsp_valid, b_rsp_valid}, 0);
            chk("reinit_adr", mem_adr, i);
        end
        sample(); chk("reinit_done", init_done, 1);
        tick(); drive_a(1, 0, 4'h3, 8'h00);
        sample(); chk("post_rst_ready", a_ready, 1);
        tick(); drive_a(0, 0, 0, 0);
        sample(); chk("post_rst_rsp", a_rsp_valid, 1); chk("post_rst_dat", a_dat_r, 8'h00);

        repeat (2) tick();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Two-requester round-robin arbiter and initialiser for the single-port 16x8 synchronous-read RAM. After reset it clears every RAM location. It then shares the RAM's single address/write port between requesters A and B, one access per cycle, and returns a one-cycle-latency response to whichever requester issued each access. It sits directly in front of the RAM; the RAM's adr/we/dat_w/dat_r connect to this block's mem_* ports.

## Interface

Parameters:
- AW, 4, address width; RAM depth is 2^AW.
- DW, 8, data width.
- INIT_VAL, 8'h00, value written to every location during initialisation.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- init_done  out  1  high once initialisation has completed.
- a_valid  in  1  requester A has a request.
- a_ready  out  1  A's request is accepted this cycle.
- a_we  in  1  1 = write, 0 = read.
- a_adr  in  AW  request address.
- a_dat_w  in  DW  write data.
- a_rsp_valid  out  1  response for A's previously accepted request.
- a_dat_r  out  DW  read data; valid with a_rsp_valid.
- b_valid, b_ready, b_we, b_adr, b_dat_w, b_rsp_valid, b_dat_r: same meanings for requester B.
- mem_adr  out  AW  RAM address.
- mem_we  out  1  RAM write enable.
- mem_dat_w  out  DW  RAM write data.
- mem_dat_r  in  DW  RAM read data. The RAM registers the address on the edge; data is valid combinationally in the following cycle.

## Operation

- FSM states are INIT and RUN. rst forces INIT and clears the init counter to 0.
- INIT:
  - mem_we=1, mem_adr=counter, mem_dat_w=INIT_VAL; counter increments every cycle.
  - When counter = 2^AW-1 is written, the FSM moves to RUN. INIT lasts exactly 2^AW cycles.
  - a_ready=b_ready=0 throughout.
- RUN, arbitration (combinational in the current cycle):
  - If only one requester has valid high, it is granted.
  - If both have valid high, the requester not granted most recently is granted.
  - The last-grant pointer updates on every grant. Its reset value is B, so A wins the first tie.
  - Grant drives x_ready=1 and routes x_adr, x_dat_w and x_we to mem_adr, mem_dat_w and mem_we.
  - With no grant: mem_we=0, mem_adr=0, mem_dat_w=0.
- Handshake:
  - Transfer occurs when x_valid and x_ready are both high.
  - Requesters hold adr/we/dat_w stable while valid is high and ready is low.
  - A requester may withdraw valid only after its transfer.
- Issue register, loaded on every edge with the current grant:
  - iss_vld: a grant occurred.
  - iss_id: A or B.
  - iss_we: the granted access was a write.
- Response:
  - In the cycle after a grant, x_rsp_valid=1 for the issuing requester, for both reads and writes.
  - x_dat_r = mem_dat_r for a read and 0 for a write.
  - When x_rsp_valid=0, x_dat_r=0.
  - There is no response backpressure.
- Throughput is one access per cycle in total; back-to-back grants to the same requester are allowed.
- A read issued the cycle after a write to the same address returns the new data.
- If A and B target the same address in the same cycle, they are serialised in grant order.

## Timing

- Reset values of all outputs are 0: init_done, a_ready, b_ready, a_rsp_valid, b_rsp_valid, a_dat_r, b_dat_r, mem_adr, mem_dat_w.
- mem_we is 0 while rst is high and becomes 1 in the first INIT cycle after release.
- Reset asserted mid-operation:
  - All outputs return to reset values immediately, asynchronously.
  - In-flight responses are dropped (iss_vld cleared).
  - INIT reruns in full.
- Timeline from rst release: INIT occupies cycles 0..2^AW-1; init_done=1 and the first grant possible in cycle 2^AW.
- Request latency: ready is granted in the same cycle as valid when uncontested; the response follows 1 cycle after the grant.
- Under continuous contention each requester is granted every other cycle; maximum wait is 1 cycle.
- init_done stays 1 until the next rst.

## Test plan

- Release rst -> 16 cycles with mem_we=1, mem_adr=0..15, mem_dat_w=00; init_done=1 in cycle 16. A read of addr 7 then returns a_dat_r=00.
- In RUN, A writes adr 3=5A, then reads adr 3 the next cycle -> write response (a_dat_r=00), then read response one cycle after the read grant with a_dat_r=5A.
- A and B hold valid continuously with reads of 1 and 2 -> grants A,B,A,B,... (A first). Each x_rsp_valid pulses one cycle after its grant with the correct data.
- Same cycle: B writes adr F=C3 and A reads adr F, with pointer favouring B -> B granted, A granted next cycle, A receives C3.
- Hold a_valid=1 during INIT -> a_ready=0 for all 16 INIT cycles and a_ready=1 in cycle 16.
- Assert rst for 1 cycle mid-traffic with a response pending -> all outputs go to 0 immediately and no stale rsp_valid appears. INIT reruns, and a read of a previously written location returns 00.
